// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer for the 10-bit datapath: decodes one instruction per
// Exec handshake and steps the register file, ALU registers and bus drivers through it.
module instr_sequencer #(
  parameter int OPW = 4,
  parameter int RAW = 2
) (
  input  logic                    CLKb,
  input  logic                    RST,
  input  logic                    Exec,
  input  logic [OPW+2*RAW+1:0]    INSTR,
  output logic                    IRin,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Err,
  output logic                    ENW,
  output logic [RAW-1:0]          WRA,
  output logic                    ENR0,
  output logic                    ENR1,
  output logic [RAW-1:0]          RDA0,
  output logic [RAW-1:0]          RDA1,
  output logic                    Ain,
  output logic                    Gin,
  output logic                    Gout,
  output logic                    Extrn,
  output logic [2:0]              ALUcont
);

  localparam int RY_LSB = 2;
  localparam int RX_LSB = 2 + RAW;
  localparam int OP_LSB = 2 + 2 * RAW;

  localparam logic [OPW-1:0] OP_LOAD = OPW'(0);
  localparam logic [OPW-1:0] OP_MOV  = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(2);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(6);
  localparam logic [OPW-1:0] OP_LSL  = OPW'(8);

  typedef enum logic [1:0] {S_IDLE, S_T1, S_T2, S_T3} state_t;

  state_t          state_q, state_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [RAW-1:0]  rx_q, rx_d, ry_q, ry_d;
  logic            is_alu, is_two;
  logic            unused_instr;

  assign unused_instr = ^INSTR[1:0];
  assign is_alu = (op_q >= OP_ADD) && (op_q <= OP_LSL);
  assign is_two = (op_q <= OP_XOR);

  always_ff @(posedge CLKb) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
    op_q <= op_d;
    rx_q <= rx_d;
    ry_q <= ry_d;
  end

  // Reset overrides every output so no write can land on the falling edge of a reset cycle.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    IRin    = 1'b0;
    Busy    = 1'b0;
    Done    = 1'b0;
    Err     = 1'b0;
    ENW     = 1'b0;
    WRA     = '0;
    ENR0    = 1'b0;
    ENR1    = 1'b0;
    RDA0    = '0;
    RDA1    = '0;
    Ain     = 1'b0;
    Gin     = 1'b0;
    Gout    = 1'b0;
    Extrn   = 1'b0;
    ALUcont = 3'd0;
    if (RST) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          IRin = Exec;
          if (Exec) begin
            op_d    = INSTR[OP_LSB +: OPW];
            rx_d    = INSTR[RX_LSB +: RAW];
            ry_d    = INSTR[RY_LSB +: RAW];
            state_d = S_T1;
          end
        end
        S_T1: begin
          Busy = 1'b1;
          if (op_q == OP_LOAD) begin
            Extrn   = 1'b1;
            ENW     = 1'b1;
            WRA     = rx_q;
            Done    = 1'b1;
            state_d = S_IDLE;
          end else if (op_q == OP_MOV) begin
            ENR0    = 1'b1;
            RDA0    = ry_q;
            ENW     = 1'b1;
            WRA     = rx_q;
            Done    = 1'b1;
            state_d = S_IDLE;
          end else if (is_alu) begin
            ENR0    = 1'b1;
            RDA0    = rx_q;
            Ain     = 1'b1;
            state_d = S_T2;
          end else begin
            Done    = 1'b1;
            Err     = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_T2: begin
          // Single-operand ops (INV, LSL) leave the second read port idle.
          Busy    = 1'b1;
          Gin     = 1'b1;
          ALUcont = 3'(op_q - OP_ADD);
          if (is_two) begin
            ENR1 = 1'b1;
            RDA1 = ry_q;
          end
          state_d = S_T3;
        end
        S_T3: begin
          Busy    = 1'b1;
          Gout    = 1'b1;
          ENW     = 1'b1;
          WRA     = rx_q;
          Done    = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: per-cycle control vectors from an instruction-level model,
// plus a stub datapath whose register contents are compared with architectural results.
module tb_instr_sequencer;

  logic       CLKb = 1'b0;
  logic       RST = 1'b1;
  logic       Exec = 1'b0;
  logic [9:0] INSTR = 10'd0;
  logic       IRin, Busy, Done, Err, ENW, ENR0, ENR1, Ain, Gin, Gout, Extrn;
  logic [1:0] WRA, RDA0, RDA1;
  logic [2:0] ALUcont;

  instr_sequencer #(.OPW(4), .RAW(2)) dut (
    .CLKb(CLKb), .RST(RST), .Exec(Exec), .INSTR(INSTR),
    .IRin(IRin), .Busy(Busy), .Done(Done), .Err(Err),
    .ENW(ENW), .WRA(WRA), .ENR0(ENR0), .ENR1(ENR1),
    .RDA0(RDA0), .RDA1(RDA1), .Ain(Ain), .Gin(Gin),
    .Gout(Gout), .Extrn(Extrn), .ALUcont(ALUcont)
  );

  always #5 CLKb = ~CLKb;

  int checks = 0;
  int passed = 0;

  logic [19:0] obs;
  assign obs = {IRin, Busy, Done, Err, ENW, WRA, ENR0, ENR1, RDA0, RDA1,
                Ain, Gin, Gout, Extrn, ALUcont};

  // Stub datapath driven by the sequencer's control outputs.
  logic [9:0] ext_data = 10'd0;
  logic [9:0] dp_r [4];
  logic [9:0] dp_a, dp_g, bus;
  logic [9:0] m_r [4];

  function automatic logic [9:0] dp_alu(input logic [2:0] f, input logic [9:0] a, input logic [9:0] b);
    case (f)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return a << 1;
      default: return 10'h3ff;
    endcase
  endfunction

  always_comb begin
    bus = 10'd0;
    if (Extrn)     bus = ext_data;
    else if (Gout) bus = dp_g;
    else if (ENR0) bus = dp_r[RDA0];
  end

  always @(posedge CLKb) begin
    if (Ain) dp_a <= bus;
    if (Gin) dp_g <= dp_alu(ALUcont, dp_a, ENR1 ? dp_r[RDA1] : 10'd0);
  end

  always @(negedge CLKb) begin
    if (ENW) dp_r[WRA] <= bus;
  end

  // Expected control vector for cycle k of an instruction (k=0 is the accept cycle).
  function automatic logic [19:0] exp_vec(input logic [3:0] op, input logic [1:0] rx,
                                          input logic [1:0] ry, input int k);
    logic irin, busy, done, err, enw, enr0, enr1, ain, gin, gout, extrn;
    logic [1:0] wra, rda0, rda1;
    logic [2:0] aluc;
    {irin, busy, done, err, enw, enr0, enr1, ain, gin, gout, extrn} = '0;
    {wra, rda0, rda1, aluc} = '0;
    if (k == 0) irin = 1'b1;
    else busy = 1'b1;
    if (op == 4'd0 && k == 1) begin
      extrn = 1'b1; enw = 1'b1; wra = rx; done = 1'b1;
    end else if (op == 4'd1 && k == 1) begin
      enr0 = 1'b1; rda0 = ry; enw = 1'b1; wra = rx; done = 1'b1;
    end else if (op >= 4'd2 && op <= 4'd8) begin
      if (k == 1) begin
        enr0 = 1'b1; rda0 = rx; ain = 1'b1;
      end else if (k == 2) begin
        gin = 1'b1;
        aluc = 3'(op - 4'd2);
        if (op <= 4'd6) begin enr1 = 1'b1; rda1 = ry; end
      end else if (k == 3) begin
        gout = 1'b1; enw = 1'b1; wra = rx; done = 1'b1;
      end
    end else if (op >= 4'd9 && k == 1) begin
      done = 1'b1; err = 1'b1;
    end
    return {irin, busy, done, err, enw, wra, enr0, enr1, rda0, rda1, ain, gin, gout, extrn, aluc};
  endfunction

  task automatic check_vec(input string tag, input logic [19:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic check_reg(input string tag, input logic [9:0] got, input logic [9:0] expv);
    checks++;
    assert (got === expv) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, expv);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) check_reg($sformatf("%s_r%0d", tag, i), dp_r[i], m_r[i]);
  endtask

  task automatic cyc(input logic rst, input logic ex, input logic [9:0] ins);
    @(posedge CLKb);
    #1;
    RST = rst;
    Exec = ex;
    INSTR = ins;
    #3;
  endtask

  // exec_busy: 0 = Exec low while busy, 1 = Exec high, 2 = random.
  task automatic run_instr(input logic [9:0] ins, input logic [9:0] ext, input int exec_busy,
                           input int gap);
    logic [3:0] op;
    logic [1:0] rx, ry;
    logic [9:0] a, b;
    int n;
    op = ins[9:6];
    rx = ins[5:4];
    ry = ins[3:2];
    ext_data = ext;
    cyc(1'b0, 1'b1, ins);
    check_vec($sformatf("accept_%h", ins), exp_vec(op, rx, ry, 0));
    n = (op >= 4'd2 && op <= 4'd8) ? 3 : 1;
    for (int k = 1; k <= n; k++) begin
      cyc(1'b0, (exec_busy == 2) ? 1'($urandom_range(0, 1)) : (exec_busy == 1), 10'($urandom));
      check_vec($sformatf("ins%h_k%0d", ins, k), exp_vec(op, rx, ry, k));
    end
    a = m_r[rx];
    b = m_r[ry];
    case (op)
      4'd0: m_r[rx] = ext;
      4'd1: m_r[rx] = b;
      4'd2: m_r[rx] = a + b;
      4'd3: m_r[rx] = a - b;
      4'd4: m_r[rx] = a & b;
      4'd5: m_r[rx] = a | b;
      4'd6: m_r[rx] = a ^ b;
      4'd7: m_r[rx] = ~a;
      4'd8: m_r[rx] = {a[8:0], 1'b0};
      default: ;
    endcase
    @(negedge CLKb);
    #1;
    check_regs($sformatf("regs_%h", ins));
    for (int g = 0; g < gap; g++) begin
      cyc(1'b0, 1'b0, 10'($urandom));
      check_vec("idle_gap", 20'd0);
    end
  endtask

  initial begin
    // Reset held with Exec asserted: reset must win.
    cyc(1'b1, 1'b1, 10'h030);
    check_vec("reset_c0", 20'd0);
    cyc(1'b1, 1'b1, 10'h030);
    check_vec("reset_c1", 20'd0);
    cyc(1'b0, 1'b0, 10'h030);
    check_vec("idle_after_reset", 20'd0);

    run_instr(10'h000, 10'($urandom), 0, 0);
    run_instr(10'h010, 10'($urandom), 2, 0);
    run_instr(10'h020, 10'($urandom), 2, 0);
    run_instr(10'h030, 10'h2a5, 0, 1);
    run_instr(10'h04c, 10'($urandom), 0, 1);
    check_reg("mov_r0_eq_r3", dp_r[0], 10'h2a5);

    run_instr(10'h010, 10'h005, 0, 0);
    run_instr(10'h020, 10'h003, 0, 0);
    run_instr(10'h098, 10'($urandom), 1, 0);
    check_reg("add_r1", dp_r[1], 10'h008);

    run_instr(10'h3c0, 10'($urandom), 0, 0);
    run_instr(10'h1e0, 10'($urandom), 0, 1);

    // SUB R0,R1 abandoned by reset during its second step.
    cyc(1'b0, 1'b1, 10'h0c4);
    check_vec("sub_accept", exp_vec(4'd3, 2'd0, 2'd1, 0));
    cyc(1'b0, 1'b0, 10'($urandom));
    check_vec("sub_t1", exp_vec(4'd3, 2'd0, 2'd1, 1));
    cyc(1'b1, 1'b1, 10'($urandom));
    check_vec("sub_rst_mid", 20'd0);
    cyc(1'b0, 1'b0, 10'($urandom));
    check_vec("idle_after_abort", 20'd0);
    @(negedge CLKb);
    #1;
    check_regs("after_abort");

    for (int i = 0; i < 200; i++) begin
      run_instr(10'($urandom), 10'($urandom), 2, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle control FSM for the 10-bit datapath.
- Accepts one instruction word per Exec handshake, decodes it, and sequences the register file (ENW/WRA, ENR0/RDA0, ENR1/RDA1), the ALU operand/result registers (Ain, Gin, Gout) and the external-data mux (Extrn).
- Sits between the instruction register and the datapath. Every register-file write it schedules lands on the falling CLKb edge inside the cycle where it asserts ENW.

Parameters:
- OPW, 4, opcode field width (INSTR[9:6])
- RAW, 2, register address width (4 registers)

Ports:
- CLKb  in  1  system clock; FSM state updates on rising edge
- RST  in  1  synchronous active-high reset
- Exec  in  1  start request; sampled only in IDLE
- INSTR  in  10  instruction word: [9:6] op, [5:4] Rx, [3:2] Ry, [1:0] ignored
- IRin  out  1  load instruction register; equals Exec while in IDLE
- Busy  out  1  high in any state other than IDLE
- Done  out  1  one-cycle pulse in the final state of an instruction
- Err  out  1  one-cycle pulse with Done on an illegal opcode
- ENW  out  1  register-file write enable
- WRA  out  2  write address
- ENR0, ENR1  out  1 each  read-port enables
- RDA0, RDA1  out  2 each  read addresses
- Ain  out  1  load ALU operand A
- Gin  out  1  load ALU result G
- Gout  out  1  drive G onto the bus
- Extrn  out  1  drive the external data input onto the bus
- ALUcont  out  3  ALU function select

Behaviour:
- One clock, CLKb. Reset is synchronous and active-high (RST), sampled on the rising edge of CLKb.
- State register on the rising edge. Outputs are decoded combinationally from the state and the latched op/Rx/Ry. IRin is the only output that depends on Exec.
- While RST=1 every output is forced to 0 combinationally, so no register-file write can occur at the falling edge of a reset cycle.
- After reset: state=IDLE. Outputs otherwise unused are 0; all addresses and ALUcont are 0.
- Opcodes:
  - 0000 LOAD Rx←ext
  - 0001 MOV Rx←Ry
  - 0010 ADD, ALUcont 000
  - 0011 SUB, ALUcont 001
  - 0100 AND, ALUcont 010
  - 0101 OR, ALUcont 011
  - 0110 XOR, ALUcont 100
  - 0111 INV, ALUcont 101
  - 1000 LSL, ALUcont 110
  - 1001–1111 illegal
- IDLE:
  - Exec=1 → IRin=1, capture INSTR[9:2] internally, go to T1.
  - Exec=0 → stay in IDLE.
- T1:
  - LOAD: Extrn=1, ENW=1, WRA=Rx, Done=1 → IDLE.
  - MOV: ENR0=1, RDA0=Ry, ENW=1, WRA=Rx, Done=1 → IDLE.
  - ALU ops: ENR0=1, RDA0=Rx, Ain=1 → T2.
  - Illegal: Done=1, Err=1, no enables → IDLE.
- T2, two-operand ops (ADD–XOR): ENR1=1, RDA1=Ry, ALUcont=code, Gin=1 → T3.
- T2, one-operand ops (INV, LSL): ENR1=0, ALUcont=code, Gin=1 → T3.
- T3: Gout=1, ENW=1, WRA=Rx, Done=1 → IDLE.
- Latency, counted from the Exec-accept cycle to the Done cycle:
  - LOAD/MOV/illegal: 1 cycle after accept.
  - ALU ops: 3 cycles after accept.
- Back-to-back: Exec=1 in the IDLE cycle immediately after Done is accepted. No bubble beyond IDLE.
- Exec while Busy=1 is ignored (not queued). INSTR changes while busy have no effect.
- Rx==Ry is legal (e.g. ADD R2,R2 reads R2 on both ports).
- RST mid-instruction: the next state is IDLE, the instruction is abandoned, and no Done/Err is produced.
- RST and Exec asserted together: reset wins, IRin=0.
- Exactly one of Extrn/Gout/ENR0-driven-bus is active in any cycle that asserts ENW.

Test Plan:
- Reset with Exec=1 for 2 cycles → all outputs 0, Busy=0, IRin=0; after release, IDLE.
- LOAD R3, INSTR=0x030, Exec pulse → next cycle Extrn=1, ENW=1, WRA=3, Done=1; Busy high for exactly 1 cycle.
- MOV R0,R3, INSTR=0x04C → T1: ENR0=1, RDA0=3, ENW=1, WRA=0, Done=1; R0 holds R3's value after the falling edge.
- ADD R1,R2, INSTR=0x098, with R1=0x005 and R2=0x003:
  - T1: Ain=1, RDA0=1.
  - T2: ENR1=1, RDA1=2, ALUcont=000, Gin=1.
  - T3: Gout=1, ENW=1, WRA=1, Done=1.
  - R1=0x008 afterwards.
  - A second Exec during T2 is ignored.
- Illegal INSTR=0x3C0 → next cycle Done=1, Err=1, ENW=0, then IDLE. INV R2 (0x1E0) then completes in 4 cycles with ENR1=0 in T2.
- RST asserted in T2 of SUB R0,R1 (0x0C4) → ENW never asserted, Done never pulses, IDLE next cycle, and the registers are unchanged.
